// File: rtl/check.sv
// Result checker: pairs each expected-result word with the captured DUT vector,
// compares the two under a bitmask, writes one result record per vector and counts pass/fail.
module check #(
  parameter int ADDR_WIDTH = 20,
  parameter int STF_WIDTH  = 24,
  parameter int ORV_WIDTH  = 8,
  parameter int CHF_WIDTH  = STF_WIDTH + ORV_WIDTH + ADDR_WIDTH,
  parameter int SCC_WIDTH  = 5,
  parameter int SCD_WIDTH  = 24,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [CHF_WIDTH-1:0] cfifo_data,
  output logic                 cfifo_rdreq,
  input  logic                 cfifo_rdempty,
  input  logic [STF_WIDTH-1:0] dfifo_data,
  output logic                 dfifo_rdreq,
  input  logic                 dfifo_rdempty,
  output logic [CHF_WIDTH-1:0] rfifo_data,
  output logic                 rfifo_wrreq,
  input  logic                 rfifo_wrfull,
  input  logic [SCC_WIDTH-1:0] sc_cmd,
  input  logic [SCD_WIDTH-1:0] sc_data,
  output logic                 sc_ready,
  input  logic                 cnt_clear,
  output logic [CNT_WIDTH-1:0] pass_count,
  output logic [CNT_WIDTH-1:0] fail_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_COMPARE,
    S_WRITE
  } state_e;

  localparam logic [SCC_WIDTH-1:0] CMD_LOAD_MASK = SCC_WIDTH'(1);

  // Result record; the orv LSB slot carries the fail flag.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  addr;
    logic [ORV_WIDTH-2:0]   orv_hi;
    logic                   fail;
    logic [STF_WIDTH-1:0]   mismatch;
  } rec_t;

  state_e                state_q, state_d;
  logic                  sc_ready_q, sc_ready_d;
  logic [STF_WIDTH-1:0]  bitmask_q, bitmask_d;
  logic [STF_WIDTH-1:0]  exp_q, exp_d;
  logic [STF_WIDTH-1:0]  dut_q, dut_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ORV_WIDTH-2:0]  orv_q, orv_d;
  logic [STF_WIDTH-1:0]  mismatch_q, mismatch_d;
  logic                  fail_q, fail_d;
  logic [CNT_WIDTH-1:0]  pass_cnt_q, pass_cnt_d;
  logic [CNT_WIDTH-1:0]  fail_cnt_q, fail_cnt_d;
  logic                  rd_en, wr_en;
  logic                  both_avail;
  logic                  unused_orv_lsb;
  rec_t                  rec;

  assign both_avail     = ~cfifo_rdempty & ~dfifo_rdempty;
  assign unused_orv_lsb = cfifo_data[0];

  always_comb begin
    state_d    = state_q;
    bitmask_d  = bitmask_q;
    exp_d      = exp_q;
    dut_d      = dut_q;
    addr_d     = addr_q;
    orv_d      = orv_q;
    mismatch_d = mismatch_q;
    fail_d     = fail_q;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    case (state_q)
      S_IDLE: begin
        // sc_ready_q gates both paths so nothing happens before the first post-reset edge
        if (sc_ready_q && sc_cmd == CMD_LOAD_MASK)
          bitmask_d = sc_data[STF_WIDTH-1:0];
        else if (sc_ready_q && both_avail)
          state_d = S_FETCH;
      end
      S_FETCH: begin
        if (both_avail) begin
          rd_en   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        exp_d   = cfifo_data[CHF_WIDTH-1 -: STF_WIDTH];
        addr_d  = cfifo_data[ORV_WIDTH +: ADDR_WIDTH];
        orv_d   = cfifo_data[ORV_WIDTH-1:1];
        dut_d   = dfifo_data;
        state_d = S_COMPARE;
      end
      S_COMPARE: begin
        mismatch_d = (dut_q ^ exp_q) & bitmask_q;
        fail_d     = |((dut_q ^ exp_q) & bitmask_q);
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        if (!rfifo_wrfull) begin
          wr_en   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    sc_ready_d = (state_d == S_IDLE);
  end

  always_comb begin
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    if (cnt_clear) begin
      pass_cnt_d = '0;
      fail_cnt_d = '0;
    end else if (wr_en) begin
      if (fail_q) begin
        if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_WIDTH'(1);
      end else begin
        if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      sc_ready_q <= 1'b0;
      bitmask_q  <= '1;
      exp_q      <= '0;
      dut_q      <= '0;
      addr_q     <= '0;
      orv_q      <= '0;
      mismatch_q <= '0;
      fail_q     <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sc_ready_q <= sc_ready_d;
      bitmask_q  <= bitmask_d;
      exp_q      <= exp_d;
      dut_q      <= dut_d;
      addr_q     <= addr_d;
      orv_q      <= orv_d;
      mismatch_q <= mismatch_d;
      fail_q     <= fail_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  // Record fields only change in WAIT/COMPARE, so the word holds steady through WRITE.
  always_comb begin
    rec.addr     = addr_q;
    rec.orv_hi   = orv_q;
    rec.fail     = fail_q;
    rec.mismatch = mismatch_q;
  end

  assign rfifo_data  = rec;
  assign rfifo_wrreq = wr_en;
  assign cfifo_rdreq = rd_en;
  assign dfifo_rdreq = rd_en;
  assign sc_ready    = sc_ready_q;
  assign pass_count  = pass_cnt_q;
  assign fail_count  = fail_cnt_q;

endmodule

// File: tb/tb_check.sv
// Directed bench for check: FIFO models around the DUT, hand-computed records and counts.
// Counters are built 8 bits wide so saturation is reachable in a short run.
module tb_check;
  localparam int AW = 20, SW = 24, OW = 8, CW = 52, CCW = 5, CDW = 24, NW = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [CW-1:0] cfifo_data = '0;
  logic          cfifo_rdreq, cfifo_rdempty;
  logic [SW-1:0] dfifo_data = '0;
  logic          dfifo_rdreq, dfifo_rdempty;
  logic [CW-1:0] rfifo_data;
  logic          rfifo_wrreq;
  logic          rfifo_wrfull = 1'b0;
  logic [CCW-1:0] sc_cmd = '0;
  logic [CDW-1:0] sc_data = '0;
  logic          sc_ready;
  logic          cnt_clear = 1'b0;
  logic [NW-1:0] pass_count, fail_count;

  check #(.ADDR_WIDTH(AW), .STF_WIDTH(SW), .ORV_WIDTH(OW), .CHF_WIDTH(CW),
          .SCC_WIDTH(CCW), .SCD_WIDTH(CDW), .CNT_WIDTH(NW)) dut (
    .clock(clock), .reset_n(reset_n),
    .cfifo_data(cfifo_data), .cfifo_rdreq(cfifo_rdreq), .cfifo_rdempty(cfifo_rdempty),
    .dfifo_data(dfifo_data), .dfifo_rdreq(dfifo_rdreq), .dfifo_rdempty(dfifo_rdempty),
    .rfifo_data(rfifo_data), .rfifo_wrreq(rfifo_wrreq), .rfifo_wrfull(rfifo_wrfull),
    .sc_cmd(sc_cmd), .sc_data(sc_data), .sc_ready(sc_ready),
    .cnt_clear(cnt_clear), .pass_count(pass_count), .fail_count(fail_count)
  );

  always #5 clock = ~clock;

  // Non-showahead FIFO models (1-cycle read latency) and result-FIFO monitor
  logic [CW-1:0] cmem [0:1023];
  logic [SW-1:0] dmem [0:1023];
  int cwp = 0, dwp = 0, crp = 0, drp = 0;
  int wr_cnt = 0, rd_bad = 0, wr_bad = 0;
  logic [CW-1:0] last_rec = '0;

  assign cfifo_rdempty = (cwp == crp);
  assign dfifo_rdempty = (dwp == drp);

  always @(posedge clock) begin
    if (cfifo_rdreq) begin
      if (cwp == crp) rd_bad <= rd_bad + 1;
      else begin cfifo_data <= cmem[crp]; crp <= crp + 1; end
    end
    if (dfifo_rdreq) begin
      if (dwp == drp) rd_bad <= rd_bad + 1;
      else begin dfifo_data <= dmem[drp]; drp <= drp + 1; end
    end
    if (rfifo_wrreq) begin
      if (rfifo_wrfull) wr_bad <= wr_bad + 1;
      wr_cnt   <= wr_cnt + 1;
      last_rec <= rfifo_data;
    end
  end

  int tests = 0, fails = 0;
  int n, bad, base;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic push_c(input logic [SW-1:0] e, input logic [AW-1:0] a, input logic [OW-1:0] o);
    cmem[cwp] = {e, a, o};
    cwp++;
  endtask

  task automatic push_d(input logic [SW-1:0] d);
    dmem[dwp] = d;
    dwp++;
  endtask

  task automatic push(input logic [SW-1:0] e, input logic [AW-1:0] a,
                      input logic [OW-1:0] o, input logic [SW-1:0] d);
    push_c(e, a, o);
    push_d(d);
  endtask

  // Wait (bounded) for one more record beyond 'b'
  task automatic wait_rec(input string tag, input int b);
    int k;
    k = 0;
    while (wr_cnt <= b && k < 40) begin tick(); k++; end
    chk(tag, 64'(wr_cnt), 64'(b + 1));
  endtask

  task automatic load_mask(input logic [SW-1:0] m);
    sc_cmd = 5'd1; sc_data = m;
    tick();
    sc_cmd = 5'd0; sc_data = '0;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_sc_ready", 64'(sc_ready), 0);
    chk("rst_reqs", 64'({cfifo_rdreq, dfifo_rdreq, rfifo_wrreq}), 0);
    chk("rst_rdata", 64'(rfifo_data), 0);
    chk("rst_counts", 64'({pass_count, fail_count}), 0);
    reset_n = 1'b1;
    #1 chk("rel_sc_ready_low", 64'(sc_ready), 0);
    tick();
    chk("rel_sc_ready_high", 64'(sc_ready), 1);

    // Basic pass, cycle-by-cycle
    push(24'hA5A5A5, 20'h00010, 8'h00, 24'hA5A5A5);
    tick();
    chk("basic_fetch_rdreq", 64'({cfifo_rdreq, dfifo_rdreq}), 64'b11);
    chk("basic_fetch_ready", 64'(sc_ready), 0);
    tick();
    chk("basic_wait_rdreq", 64'({cfifo_rdreq, dfifo_rdreq, rfifo_wrreq}), 0);
    tick();
    chk("basic_cmp_wrreq", 64'(rfifo_wrreq), 0);
    tick();
    chk("basic_write_wrreq", 64'(rfifo_wrreq), 1);
    chk("basic_rec", 64'(rfifo_data), 64'({20'h00010, 8'h00, 24'h000000}));
    tick();
    chk("basic_counts", 64'({pass_count, fail_count}), 64'({8'd1, 8'd0}));
    chk("basic_wrcnt", 64'(wr_cnt), 1);

    // Command in the same cycle as available data: command wins, mask loads
    push(24'h123456, 20'h00020, 8'h00, 24'hFF3457);
    sc_cmd = 5'd1; sc_data = 24'h0000FF;
    tick();
    chk("prio_no_rdreq", 64'({cfifo_rdreq, dfifo_rdreq}), 0);
    chk("prio_ready", 64'(sc_ready), 1);
    sc_cmd = 5'd0; sc_data = '0;
    base = wr_cnt;
    wait_rec("mask_fail_wr", base);
    chk("mask_fail_rec", 64'(last_rec), 64'({20'h00020, 8'h01, 24'h000001}));
    chk("mask_fail_cnt", 64'(fail_count), 1);

    base = wr_cnt;
    push(24'h123456, 20'h00030, 8'hAB, 24'hFF3456);
    wait_rec("mask_pass_wr", base);
    chk("mask_pass_rec", 64'(last_rec), 64'({20'h00030, 8'hAA, 24'h000000}));
    chk("mask_pass_cnt", 64'(pass_count), 2);

    // Commands outside IDLE and unknown codes are ignored
    base = wr_cnt;
    push(24'h000000, 20'h00040, 8'h00, 24'h000001);
    tick();
    sc_cmd = 5'd1; sc_data = 24'hFFFF00;
    chk("busy_ready_low", 64'(sc_ready), 0);
    tick(); tick();
    sc_cmd = 5'd0; sc_data = '0;
    wait_rec("busy_cmd_wr", base);
    chk("busy_cmd_rec", 64'(last_rec), 64'({20'h00040, 8'h01, 24'h000001}));
    sc_cmd = 5'd2; sc_data = 24'h000000;
    tick();
    sc_cmd = 5'd0;
    base = wr_cnt;
    push(24'h000000, 20'h00041, 8'h00, 24'h000002);
    wait_rec("unk_cmd_wr", base);
    chk("unk_cmd_rec", 64'(last_rec), 64'({20'h00041, 8'h01, 24'h000002}));
    chk("unk_cmd_cnt", 64'(fail_count), 3);
    load_mask(24'hFFFFFF);

    // Backpressure in WRITE
    rfifo_wrfull = 1'b1;
    base = wr_cnt;
    push(24'h111111, 20'h00050, 8'h00, 24'h111111);
    push(24'h222222, 20'h00060, 8'h00, 24'h222220);
    tick(); tick(); tick(); tick();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (rfifo_wrreq || cfifo_rdreq || dfifo_rdreq ||
          rfifo_data !== {20'h00050, 8'h00, 24'h000000}) bad++;
      tick();
    end
    chk("bp_hold", 64'(bad), 0);
    chk("bp_no_write", 64'(wr_cnt), 64'(base));
    rfifo_wrfull = 1'b0;
    #1 chk("bp_release_wrreq", 64'(rfifo_wrreq), 1);
    tick();
    chk("bp_single_wrreq", 64'(rfifo_wrreq), 0);
    chk("bp_rec1", 64'(last_rec), 64'({20'h00050, 8'h00, 24'h000000}));
    wait_rec("bp_second_wr", base + 1);
    chk("bp_rec2", 64'(last_rec), 64'({20'h00060, 8'h01, 24'h000002}));

    // Only the check FIFO has data: no reads, ready throughout
    push_c(24'h0F0F0F, 20'h00070, 8'h00);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (cfifo_rdreq || dfifo_rdreq || !sc_ready) bad++;
      tick();
    end
    chk("empty_idle", 64'(bad), 0);
    base = wr_cnt;
    push_d(24'h0F0F0F);
    wait_rec("empty_then_wr", base);
    chk("empty_then_rec", 64'(last_rec), 64'({20'h00070, 8'h00, 24'h000000}));

    // Clear alone
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    chk("clear_counts", 64'({pass_count, fail_count}), 0);

    // 255 back-to-back failing vectors: 5 cycles each, counter reaches all ones
    base = wr_cnt;
    for (int i = 0; i < 255; i++) push(24'h000000, 20'(i), 8'h00, 24'h000001);
    n = 0;
    while (wr_cnt < base + 255 && n < 3000) begin tick(); n++; end
    chk("throughput_cycles", 64'(n), 1275);
    chk("sat_reach", 64'(fail_count), 64'hFF);
    base = wr_cnt;
    push(24'h000000, 20'h00100, 8'h00, 24'h000004);
    wait_rec("sat_wr", base);
    chk("sat_hold", 64'({pass_count, fail_count}), 64'({8'h00, 8'hFF}));

    // Clear coinciding with a pass write
    push(24'h333333, 20'h00101, 8'h00, 24'h333333);
    n = 0;
    while (!rfifo_wrreq && n < 20) begin tick(); n++; end
    chk("clr_wr_seen", 64'(rfifo_wrreq), 1);
    base = wr_cnt;
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    chk("clr_wins", 64'({pass_count, fail_count}), 0);
    chk("clr_wr_done", 64'(wr_cnt), 64'(base + 1));

    // Reset while in COMPARE
    load_mask(24'h0000FF);
    base = wr_cnt;
    push(24'h000000, 20'h00200, 8'h00, 24'h000000);
    tick(); tick(); tick();
    reset_n = 1'b0;
    #1 chk("midrst_outputs", 64'({rfifo_wrreq, cfifo_rdreq, dfifo_rdreq, sc_ready}), 0);
    chk("midrst_rdata", 64'(rfifo_data), 0);
    tick(); tick();
    chk("midrst_no_write", 64'(wr_cnt), 64'(base));
    reset_n = 1'b1;
    tick();
    push(24'h000000, 20'h00080, 8'h00, 24'h800000);
    wait_rec("midrst_next_wr", base);
    chk("midrst_mask_ones", 64'(last_rec), 64'({20'h00080, 8'h01, 24'h800000}));
    chk("midrst_counts", 64'({pass_count, fail_count}), 64'({8'd0, 8'd1}));

    chk("no_read_when_empty", 64'(rd_bad), 0);
    chk("no_write_when_full", 64'(wr_bad), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
